// File: rtl/bcd_pkg.sv
// bcd_pkg: shared definitions for the sequential binary-to-BCD converter.
//   - SEG_0..SEG_9, SEG_BLANK: active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   - nibble_t: one BCD digit
//   - state_t:  conversion FSM states (IDLE, SHIFT, DONE)
package bcd_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Double-dabble correction for one digit: a nibble of 5 or more gets +3 so
  // that the following left shift carries correctly into the next digit.
  function automatic nibble_t add3(input nibble_t n);
    if (n >= 4'd5) begin
      add3 = n + 4'd3;
    end else begin
      add3 = n;
    end
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational BCD nibble to active-low seven-segment pattern.
//   nibble : in  4  BCD digit (10..15 are not legal BCD and show blank)
//   blank  : in  1  force the display dark
//   seg    : out 7  segments {g,f,e,d,c,b,a}, active-low
module seg7_decoder
  import bcd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  // Digit lookup; blanking overrides the digit.
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative (double-dabble) binary-to-BCD converter with
// registered seven-segment drivers. One shift per input bit; latency WIDTH+1.
//   clk            : in  1         clock, rising edge
//   rst            : in  1         synchronous reset, active-low
//   start          : in  1         conversion request, sampled only in IDLE
//   bin_in         : in  WIDTH     unsigned value, captured on the accepting edge
//   busy           : out 1         conversion in progress
//   done           : out 1         one-cycle pulse, new digits valid
//   bcd_out        : out 4*DIGITS  BCD digits, units in [3:0]
//   display_unidad : out 7         units digit segments (active-low {g..a})
//   display_decena : out 7         tens digit segments
//   display_centena: out 7         hundreds digit segments
//   display_miles  : out 7         thousands digit segments
// The four display ports map digits 0..3, so DIGITS is expected to be 4.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH         = 10,
  parameter int DIGITS        = 4,
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [6:0]            display_unidad,
  output logic [6:0]            display_decena,
  output logic [6:0]            display_centena,
  output logic [6:0]            display_miles
);

  localparam int SR_W  = 4*DIGITS + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t                state_r, state_s;
  logic [SR_W-1:0]       sr_r, sr_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic                  load_out_s;
  logic                  busy_r;
  logic                  done_r;
  logic [4*DIGITS-1:0]   bcd_r;
  logic [4*DIGITS-1:0]   field_s;
  logic [DIGITS-1:0]     blank_s;
  logic                  higher_zero_s;
  logic [6:0]            seg_s [DIGITS];
  logic [6:0]            seg_r [DIGITS];

  // One double-dabble iteration: correct every BCD digit, then shift left.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] v);
    logic [SR_W-1:0] t;
    t = v;
    for (int k = 0; k < DIGITS; k++) begin
      t[WIDTH + 4*k +: 4] = add3(v[WIDTH + 4*k +: 4]);
    end
    dabble_step = {t[SR_W-2:0], 1'b0};
  endfunction

  // Next-state and datapath control for the conversion FSM.
  always_comb begin
    state_s    = state_r;
    sr_s       = sr_r;
    cnt_s      = cnt_r;
    load_out_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          sr_s    = {{(4*DIGITS){1'b0}}, bin_in};
          cnt_s   = '0;
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        sr_s  = dabble_step(sr_r);
        cnt_s = cnt_r + CNT_W'(1);
        if (cnt_r == CNT_W'(WIDTH - 1)) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        load_out_s = 1'b1;
        state_s    = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // BCD field of the shift register feeds the decoders directly; it is only
  // meaningful (and only captured) in DONE.
  assign field_s = sr_r[SR_W-1 -: 4*DIGITS];

  // Leading-zero blanking: scan from the top digit down, a digit goes dark
  // while it and everything above it are zero. The units digit never blanks.
  always_comb begin
    higher_zero_s = 1'b1;
    blank_s       = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      higher_zero_s = higher_zero_s && (field_s[4*k +: 4] == 4'd0);
      blank_s[k]    = BLANK_LEADING && (k != 0) && higher_zero_s;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decoder u_dec (
      .nibble (field_s[4*g +: 4]),
      .blank  (blank_s[g]),
      .seg    (seg_s[g])
    );
  end

  // FSM state, shift register and bit counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      sr_r    <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      sr_r    <= sr_s;
      cnt_r   <= cnt_s;
    end
  end

  // Handshake and result registers; results hold until the next DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      bcd_r  <= '0;
      for (int k = 0; k < DIGITS; k++) begin
        seg_r[k] <= (BLANK_LEADING && (k != 0)) ? SEG_BLANK : SEG_0;
      end
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= load_out_s;
      if (load_out_s) begin
        bcd_r <= field_s;
        for (int k = 0; k < DIGITS; k++) begin
          seg_r[k] <= seg_s[k];
        end
      end else begin
        bcd_r <= bcd_r;
      end
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign bcd_out         = bcd_r;
  assign display_unidad  = seg_r[0];
  assign display_decena  = seg_r[1];
  assign display_centena = seg_r[2];
  assign display_miles   = seg_r[3];

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  bin_in = 10'd0;

  logic        busy, done, busy_b, done_b;
  logic [15:0] bcd_out, bcd_b;
  logic [6:0]  d_u, d_d, d_c, d_m;
  logic [6:0]  b_u, b_d, b_c, b_m;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(10), .DIGITS(4), .BLANK_LEADING(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out),
    .display_unidad(d_u), .display_decena(d_d),
    .display_centena(d_c), .display_miles(d_m)
  );

  bin2bcd_seq #(.WIDTH(10), .DIGITS(4), .BLANK_LEADING(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b),
    .display_unidad(b_u), .display_decena(b_d),
    .display_centena(b_c), .display_miles(b_m)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_disp(input string tag, input logic [6:0] m, input logic [6:0] c,
                            input logic [6:0] d, input logic [6:0] u);
    check({tag, " miles"},   {25'd0, d_m}, {25'd0, m});
    check({tag, " centena"}, {25'd0, d_c}, {25'd0, c});
    check({tag, " decena"},  {25'd0, d_d}, {25'd0, d});
    check({tag, " unidad"},  {25'd0, d_u}, {25'd0, u});
  endtask

  task automatic check_disp_b(input string tag, input logic [6:0] m, input logic [6:0] c,
                              input logic [6:0] d, input logic [6:0] u);
    check({tag, " b_miles"},   {25'd0, b_m}, {25'd0, m});
    check({tag, " b_centena"}, {25'd0, b_c}, {25'd0, c});
    check({tag, " b_decena"},  {25'd0, b_d}, {25'd0, d});
    check({tag, " b_unidad"},  {25'd0, b_u}, {25'd0, u});
  endtask

  // Accept a conversion, scramble bin_in afterwards, measure latency to done.
  task automatic convert(input string tag, input logic [9:0] v, input logic [15:0] exp_bcd);
    int n;
    bin_in = v;
    start  = 1'b1;
    step();
    start  = 1'b0;
    bin_in = ~v;
    check({tag, " busy_after_accept"}, {31'd0, busy}, 32'd1);
    check({tag, " done_after_accept"}, {31'd0, done}, 32'd0);
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    check({tag, " latency"}, n, 32'd11);
    check({tag, " bcd"}, {16'd0, bcd_out}, {16'd0, exp_bcd});
    check({tag, " bcd_b"}, {16'd0, bcd_b}, {16'd0, exp_bcd});
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    step();
    check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
    check({tag, " bcd_hold"}, {16'd0, bcd_out}, {16'd0, exp_bcd});
  endtask

  logic [9:0]  vin  [6];
  logic [15:0] vexp [6];

  initial begin
    int n;
    int pulses;

    // Reset and idle
    step();
    step();
    rst = 1'b1;
    step(); step(); step();
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst bcd", {16'd0, bcd_out}, 32'h0000);
    check_disp("rst", S0, S0, S0, S0);
    check_disp_b("rst", SB, SB, SB, S0);

    // Full-scale input
    convert("c1023", 10'd1023, 16'h1023);
    check_disp("c1023", S1, S0, S2, S3);
    check_disp_b("c1023", S1, S0, S2, S3);

    // Decade boundaries
    vin[0] = 10'd0;   vexp[0] = 16'h0000;
    vin[1] = 10'd9;   vexp[1] = 16'h0009;
    vin[2] = 10'd10;  vexp[2] = 16'h0010;
    vin[3] = 10'd99;  vexp[3] = 16'h0099;
    vin[4] = 10'd100; vexp[4] = 16'h0100;
    vin[5] = 10'd999; vexp[5] = 16'h0999;
    for (int i = 0; i < 6; i++) begin
      convert($sformatf("vec%0d", i), vin[i], vexp[i]);
    end

    // start during SHIFT (edge E+3) and DONE (edge E+11) is ignored
    bin_in = 10'd512;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      start  = (i == 3 || i == 11) ? 1'b1 : 1'b0;
      bin_in = (i == 3 || i == 11) ? 10'd7 : 10'd512;
      step();
    end
    start = 1'b0;
    check("ign done", {31'd0, done}, 32'd1);
    check("ign bcd", {16'd0, bcd_out}, 32'h0512);
    step();
    check("ign no_restart busy", {31'd0, busy}, 32'd0);
    check("ign done_low", {31'd0, done}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    check("ign no_extra_done", pulses, 32'd0);
    check("ign bcd_hold", {16'd0, bcd_out}, 32'h0512);
    convert("c7", 10'd7, 16'h0007);

    // Reset mid-conversion aborts without done
    bin_in = 10'd777;
    start  = 1'b1;
    step();
    start  = 1'b0;
    step(); step(); step(); step();
    rst = 1'b0;
    step();
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort bcd", {16'd0, bcd_out}, 32'h0000);
    check_disp("abort", S0, S0, S0, S0);
    check_disp_b("abort", SB, SB, SB, S0);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    check("abort quiet", pulses, 32'd0);
    convert("c42", 10'd42, 16'h0042);

    // Leading-zero blanking
    convert("c5", 10'd5, 16'h0005);
    check_disp("c5", S0, S0, S0, S5);
    check_disp_b("c5", SB, SB, SB, S5);
    convert("c305", 10'd305, 16'h0305);
    check_disp_b("c305", SB, S3, S0, S5);
    convert("c0", 10'd0, 16'h0000);
    check_disp_b("c0", SB, SB, SB, S0);

    // start held high: back-to-back conversions every 12 cycles
    bin_in = 10'd250;
    start  = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    check("b2b first", {31'd0, done}, 32'd1);
    n = 0;
    step();
    n++;
    while (done !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    check("b2b period", n, 32'd12);
    check("b2b bcd", {16'd0, bcd_out}, 32'h0250);
    start = 1'b0;
    for (int i = 0; i < 14; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter with 7-segment drivers. Sits directly downstream of the loadable up/down counter: takes its 10-bit count, converts it with an iterative shift-and-add-3 (double-dabble) engine under a start/busy/done handshake, and drives four active-low seven-segment displays (units, tens, hundreds, thousands). Replaces combinational conversion with a small, timing-friendly engine that needs one cycle per input bit.

## Interface
- `WIDTH`, 10, binary input width.
- `DIGITS`, 4, BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH − 1.
- `BLANK_LEADING`, 0, when 1, leading-zero digits are blanked. The units digit is never blanked.
- `clk`  in  1  single clock. All state is updated on the rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `start`  in  1  request a conversion of `bin_in`. Sampled only in IDLE.
- `bin_in`  in  WIDTH  unsigned binary value. Captured on the accepting edge.
- `busy`  out  1  conversion in progress.
- `done`  out  1  one-cycle pulse: new digits are valid.
- `bcd_out`  out  4*DIGITS  BCD digits. Units in [3:0].
- `display_unidad`, `display_decena`, `display_centena`, `display_miles`  out  7 each  segments, active-low, bit order {g,f,e,d,c,b,a}.

## Operation
- FSM states:
  - IDLE:
    - On `start`=1: load shift register {4*DIGITS zeros, `bin_in`}, clear bit counter, go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT, once per cycle:
    - Every BCD nibble ≥5 gets +3.
    - Then the whole register shifts left 1.
    - Bit counter increments.
    - After the WIDTH-th shift, go to DONE.
  - DONE (one cycle):
    - Register the BCD field into `bcd_out` and the segment outputs.
    - Pulse `done`, return to IDLE.
- `start` in SHIFT or DONE is ignored, not queued. The upstream stage re-asserts it.
- `bin_in` changes after acceptance have no effect on the running conversion.
- Segment encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
- Nibbles 10–15 cannot occur. The decoder maps them to blank.
- Leading-zero blanking (BLANK_LEADING=1): digit k is blanked iff digit k and all higher digits are zero, for k ≥ 1.
- Outputs hold the last completed result between conversions.

## Timing
- Reset (`rst`=0 at an edge):
  - State IDLE, `busy`=0, `done`=0, `bcd_out`=0.
  - All displays 1000000 ("0").
  - With BLANK_LEADING=1, all displays except units are 1111111.
- A reset asserted mid-conversion aborts immediately, with the same values. No `done` is produced.
- Edge E samples `start`=1 in IDLE:
  - `busy`=1 from E through E+WIDTH.
  - At edge E+WIDTH+1: `busy`=0, `done`=1 for exactly one cycle, new `bcd_out`/segments visible.
  - Latency: WIDTH+1 = 11 cycles.
- Earliest next accepted `start` is at edge E+WIDTH+2. Maximum throughput is one conversion per WIDTH+2 cycles.
- `busy` and `done` are never both 1.
- `start` held continuously gives back-to-back conversions every WIDTH+2 cycles.

## Structure
- Shared package `bcd_pkg` holds:
  - the segment constants SEG_0..SEG_9 and SEG_BLANK;
  - the nibble type;
  - the FSM state enum (IDLE, SHIFT, DONE).
- Sub-module `seg7_decoder` is a purely combinational nibble-plus-blank to 7-bit converter, instantiated DIGITS times.
- Top level contains the FSM, bit counter ($clog2(WIDTH+1) bits), the (4*DIGITS+WIDTH)-bit shift register, and the output registers.

## Test plan
- Reset, then 3 cycles idle → `busy`=0, `done`=0, `bcd_out`=0x0000, all displays 1000000.
- `start` with `bin_in`=1023:
  - `done` exactly 11 edges later;
  - `bcd_out`=0x1023;
  - displays miles=1111001, centena=1000000, decena=0100100, unidad=0110000.
- Conversions of 0, 9, 10, 99, 100, 999 → `bcd_out` = 0x0000, 0x0009, 0x0010, 0x0099, 0x0100, 0x0999, each with one `done` pulse.
- Start 512, then re-assert `start` with 7 at cycles 3 and 11 (during SHIFT/DONE) → only 0x0512 is produced; the next `start` in IDLE gives 0x0007.
- Start 777, pull `rst` low at cycle 5 → outputs return to reset values, no `done`. After release, a `start` with 42 gives 0x0042.
- BLANK_LEADING=1 with input 5 → miles/centena/decena = 1111111, unidad=0010010. With input 0 → only unidad shows 1000000.
